// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI initiator (SCLK idles low, MISO sampled on the
// rising edge, MOSI updated on the falling edge, MSB first) driving an 8-way
// active-low one-hot chip-select bus.
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds a 'loopback' input that
// feeds the registered MOSI back into the receive path instead of the MISO pin.
module spi_master_ctrl #(
  parameter  int DATA_W  = 32,
  parameter  int CLK_DIV = 4,
  localparam int LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cs_idx,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic [7:0]        cs,
  output logic              mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso
);

  localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(DATA_W);

  // A divider of zero would never let SCLK advance; refuse to elaborate.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } state_t;

  state_t            state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic [LEN_W-1:0]  bits_q,    bits_d;
  logic [DATA_W-1:0] tx_sh_q,   tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q,   rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [7:0]        cs_q,      cs_d;
  logic              sclk_q,    sclk_d;
  logic              mosi_q,    mosi_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [LEN_W-1:0]  eff_len;
  logic [DATA_W-1:0] tx_aligned;
  logic              sample_bit;

  // Request decode: clamp the length and left-align the word so the MSB of the
  // transfer always sits at the top of the shift register.
  always_comb begin
    eff_len    = (len > LEN_MAX) ? LEN_MAX : len;
    tx_aligned = tx_data << (LEN_MAX - eff_len);
`ifdef SPI_MASTER_LOOPBACK_EN
    sample_bit = loopback ? mosi_q : miso;
`else
    sample_bit = miso;
`endif
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every _d signal gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    bits_d    = bits_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (busy_q) begin
          // Done cycle just ended; busy drops here, so a start seen now is ignored.
          busy_d = 1'b0;
        end else if (start) begin
          busy_d = 1'b1;
          if (eff_len == '0) begin
            done_d = 1'b1;
          end else begin
            cs_d    = ~(8'h01 << cs_idx);
            tx_sh_d = tx_aligned;
            mosi_d  = tx_aligned[DATA_W-1];
            bits_d  = eff_len;
            div_d   = DIV_RELOAD;
            rx_sh_d = '0;
            state_d = SETUP;
          end
        end
      end

      SETUP, SHIFT_LO: begin
        if (div_q == '0) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
          div_d   = DIV_RELOAD;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      SHIFT_HI: begin
        if (div_q == '0) begin
          sclk_d = 1'b0;
          div_d  = DIV_RELOAD;
          if (bits_q > LEN_W'(1)) begin
            bits_d  = bits_q - LEN_W'(1);
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sh_q[DATA_W-2];
            state_d = SHIFT_LO;
          end else begin
            // Last bit: MOSI keeps its value through the hold phase.
            bits_d  = '0;
            state_d = HOLD;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_q == '0) begin
          cs_d      = 8'hff;
          sclk_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = IDLE;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments only, so every flop updates from pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bits_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 8'hff;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bits_q    <= bits_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Synthesizable SPI initiator that drives the 8-way chip-select bus, serial clock and MOSI, and samples MISO.
- It is the driving end of the same bus the SPI agent monitor observes, with identical signal semantics.
- Used as the DUT-side master, and as the stimulus source for the monitor agent in block-level benches.
- Fixed mode 0: SCLK idles low, MISO is sampled on the rising edge, MOSI changes on the falling edge, MSB first.

Parameters:
- DATA_W, 32: maximum transfer length in bits; width of tx_data and rx_data.
- CLK_DIV, 4: system clocks per SCLK half-period; legal range is 1 or more (elaboration error if 0).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- cs_idx  in  3  target slave index; captured on accept.
- len  in  $clog2(DATA_W+1)  number of bits; captured on accept.
- tx_data  in  DATA_W  transmit word, right-aligned; captured on accept.
- busy  out  1  high from the cycle after accept until done inclusive.
- done  out  1  single-cycle completion pulse.
- rx_data  out  DATA_W  received word, right-aligned, upper bits zero; holds until the next done.
- sclk  out  1  serial clock.
- cs  out  8  active-low one-hot chip select; 8'hff when idle.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset (async, immediate): state IDLE, sclk=0, cs=8'hff, mosi=0, busy=0, done=0, rx_data=0, all counters 0. Asserting reset mid-transfer aborts the transfer with no done pulse.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD.
- IDLE:
  - start=1 with len>=1 and len<=DATA_W at edge k: capture the request. From k+1, busy=1, cs[cs_idx]=0, mosi=tx_data[len-1]. Go to SETUP.
  - start=1 with len=0: no bus activity; done=1 at k+1, rx_data unchanged, busy=1 for that cycle only.
  - start=1 with len>DATA_W: clamp len to DATA_W.
- SETUP: wait CLK_DIV cycles, then sclk rises at k+1+CLK_DIV and the FSM enters SHIFT_HI.
- Rising edge i (i=0..len-1): occurs at k+1+CLK_DIV*(1+2i). miso is sampled in the same system cycle sclk goes high and shifted into the rx shift register LSB.
- Falling edge i: occurs at k+1+CLK_DIV*(2+2i). If bits remain, mosi takes the next lower tx bit.
- Last falling edge: mosi holds its value, go to HOLD.
- HOLD: wait CLK_DIV cycles. At k+1+CLK_DIV*(2*len+1): cs=8'hff, done=1, rx_data updated, sclk=0. Return to IDLE.
- busy drops the cycle after done.
- Back-to-back transfers: start may be asserted in the done cycle. It is ignored, because busy=1 is still visible. It is accepted on the following cycle, which guarantees cs is high for at least 1 clk between transfers.
- start while busy=1: ignored; no queueing.
- Inputs other than miso are don't-care outside the accept cycle.
- Bit counter and divider counter never wrap. The divider reloads to CLK_DIV-1 on every SCLK transition.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the rx path samples the internally registered mosi instead of the miso pin. The cs, sclk and mosi pins still toggle normally. rx_data equals tx_data masked to len bits.
- Undefined: no loopback port; the rx path always samples miso.

Test Plan:
- Reset: hold rst_n=0 -> cs=8'hff, sclk=0, mosi=0, busy=0, done=0, rx_data=0. Then assert rst_n=0 during bit 3 of a transfer -> outputs return to idle values immediately, and no done pulse follows.
- Basic byte, CLK_DIV=4, cs_idx=2, len=8, tx_data=8'hA5, slave returns 8'h3C on miso -> cs=8'hfb for 68 clks, 8 rising sclk edges, mosi serialises 1,0,1,0,0,1,0,1, done at k+69, rx_data=32'h0000003C.
- Full width, len=32, tx_data=32'hDEADBEEF, miso tied 1 -> 32 sclk pulses, rx_data=32'hFFFFFFFF, monitor captures a matching 32-bit mosi stream.
- len=0 and len=40 (with DATA_W=32) -> len=0 gives done at k+1 with cs untouched; len=40 gives exactly 32 sclk pulses.
- start held high continuously with CLK_DIV=1, len=4 -> consecutive transfers are separated by at least 1 cycle of cs=8'hff; start while busy is never accepted.
- With SPI_MASTER_LOOPBACK_EN defined, loopback=1, len=16, tx_data=16'h1234, miso=0 -> rx_data=32'h00001234.
